// File: rtl/moving_sum_decoder.sv
// Inverse of a WINDOW-tap moving sum: rebuilds x[n] = y[n] - y[n-1] + x[n-WINDOW] (mod 2^WIDTH).
// Optional synchronous clear input is enabled by defining MOVING_SUM_DECODER_CLEAR_EN.
module moving_sum_decoder #(
  parameter int WIDTH  = 8,
  parameter int WINDOW = 16
) (
  input  logic                    system1000,
  input  logic                    system1000_rstn,
  input  logic signed [WIDTH-1:0] sum_i,
  input  logic                    valid_i,
`ifdef MOVING_SUM_DECODER_CLEAR_EN
  input  logic                    clear_i,
`endif
  output logic signed [WIDTH-1:0] sample_o,
  output logic                    valid_o,
  output logic                    primed_o
);

  localparam int CNT_W = $clog2(WINDOW + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(WINDOW);

  // Differences wrap naturally in WIDTH bits, which is what lets sums crossing full scale decode.
  function automatic logic signed [WIDTH-1:0] wrap_decode(
    input logic signed [WIDTH-1:0] y_now,
    input logic signed [WIDTH-1:0] y_prev,
    input logic signed [WIDTH-1:0] x_old
  );
    return y_now - y_prev + x_old;
  endfunction

  logic signed [WIDTH-1:0] prev_sum;
  logic signed [WIDTH-1:0] hist [WINDOW];
  logic        [CNT_W-1:0] fill_cnt;
  logic        [CNT_W-1:0] fill_next;
  logic signed [WIDTH-1:0] x_p0;
  logic                    clear_req;

`ifdef MOVING_SUM_DECODER_CLEAR_EN
  assign clear_req = clear_i;
`else
  assign clear_req = 1'b0;
`endif

  assign x_p0 = wrap_decode(sum_i, prev_sum, hist[WINDOW-1]);

  always_comb begin
    fill_next = fill_cnt;
    if (fill_cnt != FULL) fill_next = fill_cnt + CNT_W'(1);
  end

  // Stage p0 -> p1: decode registered into sample_o alongside valid_o
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      prev_sum <= '0;
      for (int k = 0; k < WINDOW; k++) hist[k] <= '0;
      fill_cnt <= '0;
      sample_o <= '0;
      valid_o  <= 1'b0;
      primed_o <= 1'b0;
    end else if (clear_req) begin
      prev_sum <= '0;
      for (int k = 0; k < WINDOW; k++) hist[k] <= '0;
      fill_cnt <= '0;
      valid_o  <= 1'b0;
      primed_o <= 1'b0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        sample_o <= x_p0;
        prev_sum <= sum_i;
        hist[0]  <= x_p0;
        for (int k = 1; k < WINDOW; k++) hist[k] <= hist[k-1];
        fill_cnt <= fill_next;
        primed_o <= (fill_next == FULL);
      end
    end
  end

endmodule

// File: tb/tb_moving_sum_decoder.sv
// Scoreboard bench for moving_sum_decoder: driver queues expected samples, monitor checks outputs.
module tb_moving_sum_decoder;

  logic              system1000 = 1'b0;
  logic              system1000_rstn = 1'b0;
  logic signed [7:0] sum_i = '0;
  logic              valid_i = 1'b0;
  logic signed [7:0] sample_o;
  logic              valid_o;
  logic              primed_o;
`ifdef MOVING_SUM_DECODER_CLEAR_EN
  logic              clear_i = 1'b0;
`endif

  moving_sum_decoder #(.WIDTH(8), .WINDOW(16)) dut (
    .system1000      (system1000),
    .system1000_rstn (system1000_rstn),
    .sum_i           (sum_i),
    .valid_i         (valid_i),
`ifdef MOVING_SUM_DECODER_CLEAR_EN
    .clear_i         (clear_i),
`endif
    .sample_o        (sample_o),
    .valid_o         (valid_o),
    .primed_o        (primed_o)
  );

  always #5 system1000 = ~system1000;

  typedef struct packed {
    logic signed [7:0] s;
    logic              p;
  } exp_t;

  exp_t              sbq [$];
  int                total = 0;
  int                bad = 0;
  int                acc_cnt = 0;
  logic signed [7:0] last_seen = '0;
  logic signed [7:0] enc_hist [16];

  task automatic chk(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  // Monitor: pops one expectation per valid_o pulse; checks sample_o holds while idle
  always @(negedge system1000) begin
    exp_t e;
    if (!system1000_rstn) begin
      last_seen = '0;
    end else if (valid_o) begin
      if (sbq.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("sample", int'(sample_o), int'(e.s));
        chk("primed", int'(primed_o), int'(e.p));
      end
      last_seen = sample_o;
    end else begin
      chk("hold_idle", int'(sample_o), int'(last_seen));
    end
  end

  task automatic send(input logic signed [7:0] y, input logic signed [7:0] x_exp);
    exp_t e;
    valid_i = 1'b1;
    sum_i   = y;
    if (acc_cnt < 16) acc_cnt++;
    e.s = x_exp;
    e.p = (acc_cnt == 16);
    sbq.push_back(e);
    @(posedge system1000);
    #1;
  endtask

  task automatic idle();
    valid_i = 1'b0;
    @(posedge system1000);
    #1;
  endtask

  // Reference encoder: direct windowed sum over the last 16 samples
  task automatic enc_send(input logic signed [7:0] x);
    logic signed [7:0] acc;
    for (int i = 15; i > 0; i--) enc_hist[i] = enc_hist[i-1];
    enc_hist[0] = x;
    acc = '0;
    for (int i = 0; i < 16; i++) acc = acc + enc_hist[i];
    send(acc, x);
  endtask

  task automatic do_reset();
    valid_i = 1'b0;
    system1000_rstn = 1'b0;
    for (int i = 0; i < 16; i++) enc_hist[i] = '0;
    acc_cnt = 0;
    #1;
    chk("rst_sample", int'(sample_o), 0);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_primed", int'(primed_o), 0);
    @(posedge system1000);
    @(posedge system1000);
    #1;
    chk("rst_hold_valid", int'(valid_o), 0);
    system1000_rstn = 1'b1;
  endtask

  int y100 [16] = '{100, -56, 44, -112, -12, 88, -68, 32,
                    -124, -24, 76, -80, 20, 120, -36, 64};
  int xgap [24] = '{5, -3, 127, -128, 0, 1, -1, 64, -64, 100, -100, 33,
                    7, -7, 90, -90, 127, 127, -128, -128, 12, -50, 77, 2};
  int xrst [27] = '{10, -20, 30, -40, 50, -60, 70,
                    -1, 2, -3, 4, 120, -120, 8, 9, 10, 11, -12, 13, 14, -15, 16, 55, -66, 77, 1, 0};

  initial begin
    for (int i = 0; i < 16; i++) enc_hist[i] = '0;
    #2;
    chk("init_sample", int'(sample_o), 0);
    chk("init_valid", int'(valid_o), 0);
    chk("init_primed", int'(primed_o), 0);
    @(posedge system1000);
    #1;
    system1000_rstn = 1'b1;
    idle();

    // Impulse: y=5 for 16 samples then 0 -> x = 5 then zeros
    for (int n = 0; n < 16; n++) send(8'sd5, (n == 0) ? 8'sd5 : 8'sd0);
    for (int n = 0; n < 20; n++) send(8'sd0, 8'sd0);
    idle();
    do_reset();
    idle();

    // Constant x=1: y ramps 1..16 then stays at 16
    for (int n = 0; n < 16; n++) send(8'(n + 1), 8'sd1);
    for (int n = 0; n < 4; n++) send(8'sd16, 8'sd1);
    idle();
    do_reset();
    idle();

    // Wrap-around with x=100
    for (int n = 0; n < 16; n++) send(8'(y100[n]), 8'sd100);
    for (int n = 0; n < 4; n++) send(8'sd64, 8'sd100);
    idle();
    do_reset();
    idle();

    // Wrap-around with x=-128: y alternates -128/0 then settles at 0
    for (int n = 0; n < 20; n++) begin
      if (n < 16) send((n % 2 == 0) ? 8'sh80 : 8'sd0, 8'sh80);
      else        send(8'sd0, 8'sh80);
    end
    idle();
    do_reset();
    idle();

    // Valid gaps: encoder only advances on accepted samples
    for (int i = 0; i < 24; i++) begin
      if (i % 3 == 0) idle();
      if (i % 5 == 2) begin idle(); idle(); end
      enc_send(8'(xgap[i]));
    end
    idle();
    idle();
    do_reset();
    idle();

    // Reset mid-stream after 7 samples, then a fresh stream
    for (int i = 0; i < 7; i++) enc_send(8'(xrst[i]));
    idle();
    do_reset();
    for (int i = 7; i < 27; i++) enc_send(8'(xrst[i]));
    idle();

`ifdef MOVING_SUM_DECODER_CLEAR_EN
    // Clear with simultaneous valid: input dropped, state zeroed, sample_o kept
    clear_i = 1'b1;
    valid_i = 1'b1;
    sum_i   = 8'sd99;
    @(posedge system1000);
    #1;
    clear_i = 1'b0;
    valid_i = 1'b0;
    chk("clr_valid", int'(valid_o), 0);
    chk("clr_primed", int'(primed_o), 0);
    for (int i = 0; i < 16; i++) enc_hist[i] = '0;
    acc_cnt = 0;
    idle();
    for (int i = 0; i < 20; i++) enc_send(8'(xgap[i] - xrst[i]));
    idle();
`endif

    idle();
    idle();
    chk("queue_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
